// File: rtl/ntt_stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer_pkg
// Purpose  : Shared types and constants for the NTT/INTT stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ntt_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FLAG_IDLE = 2'b00;
  localparam logic [1:0] FLAG_BUSY = 2'b01;
  localparam logic [1:0] FLAG_DONE = 2'b10;
  localparam logic [1:0] FLAG_ERR  = 2'b11;

  localparam int         LAT_NTT  = 7;
  localparam int         LAT_INTT = 13;
  localparam logic [2:0] MAX_CONF = 3'd6;

  // Butterfly span saturates once the stage index exceeds the issue-index width.
  function automatic logic [2:0] stage_shift(input logic [2:0] stage, input int idx_w);
    if (int'(stage) > idx_w) return 3'(idx_w);
    return stage;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_stage_sequencer_we_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer_we_delay_line
// Purpose  : Read-enable to write-enable shifter with two selectable taps.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_stage_sequencer_we_delay_line #(
  parameter int DEPTH = 13,
  parameter int TAP_A = 7,
  parameter int TAP_B = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sel,
  output logic dout
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sr <= '0;
    else      r_sr <= {r_sr[DEPTH-2:0], din};
  end

  assign dout = sel ? r_sr[TAP_B-1] : r_sr[TAP_A-1];

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stage_sequencer
// Purpose  : Stage/issue loop controller for the mixed-radix NTT/INTT engine.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_stage_sequencer
  import ntt_stage_sequencer_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [2:0]       conf,
  input  logic             hold,
  output logic             sel,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic [2:0]       p,
  output logic             iren,
  output logic             iwen,
  output logic             ien,
  output logic [1:0]       done_flag
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic [2:0]       r_last;
  logic [2:0]       r_p;
  logic [IDX_W-1:0] r_i;
  logic [3:0]       r_cnt;
  logic [1:0]       r_flag;
  logic             w_iren;
  logic             w_ien;
  logic             w_lat_end;
  logic [2:0]       w_shift;

  assign w_lat_end = (r_cnt == (r_sel ? 4'(LAT_INTT - 1) : 4'(LAT_NTT - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iren      = 1'b0;
    w_ien       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && (conf <= MAX_CONF)) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_ien = 1'b1;
        if (!hold) begin
          w_iren = 1'b1;
          if (r_i == '1) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_ien = 1'b1;
        if (w_lat_end) w_state_nxt = (r_p == r_last) ? DONE : ISSUE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Indices, latched transform settings and host status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel  <= 1'b0;
      r_last <= '0;
      r_p    <= '0;
      r_i    <= '0;
      r_cnt  <= '0;
      r_flag <= FLAG_IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (conf <= MAX_CONF) begin
              r_sel  <= mode;
              r_last <= conf;
              r_p    <= '0;
              r_i    <= '0;
              r_flag <= FLAG_BUSY;
            end else begin
              r_flag <= FLAG_ERR;
            end
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (!hold) r_i <= r_i + 1'b1;
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_lat_end && (r_p != r_last)) begin
            r_p <= r_p + 1'b1;
            r_i <= '0;
          end
        end
        DONE: begin
          r_flag <= FLAG_DONE;
        end
        default: ;
      endcase
    end
  end

  ntt_stage_sequencer_we_delay_line #(
    .DEPTH (LAT_INTT),
    .TAP_A (LAT_NTT),
    .TAP_B (LAT_INTT)
  ) u_we_delay_line (
    .clk  (clk),
    .rst  (rst),
    .din  (w_iren),
    .sel  (r_sel),
    .dout (iwen)
  );

  assign w_shift   = stage_shift(r_p, IDX_W);
  assign j         = r_i & IDX_W'((32'd1 << w_shift) - 32'd1);
  assign k         = r_i >> w_shift;
  assign i         = r_i;
  assign p         = r_p;
  assign sel       = r_sel;
  assign iren      = w_iren;
  assign ien       = w_ien;
  assign done_flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_stage_sequencer
// Purpose  : Directed self-checking bench for ntt_stage_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [2:0] conf;
  logic       hold;
  logic       sel;
  logic [4:0] i;
  logic [4:0] j;
  logic [4:0] k;
  logic [2:0] p;
  logic       iren;
  logic       iwen;
  logic       ien;
  logic [1:0] done_flag;

  int n_err;
  int n_checks;

  // Per-cycle logs and summary metrics of the latest run (cycle 0 = start cycle).
  logic       iren_l [0:299];
  logic       iwen_l [0:299];
  logic [4:0] i_l    [0:299];
  logic [4:0] j_l    [0:299];
  logic [4:0] k_l    [0:299];
  logic [2:0] p_l    [0:299];
  logic [1:0] flag_l [0:299];
  logic       sel_l  [0:299];
  int iren_cnt, iwen_cnt, ien_cnt;
  int iren_first, iren_last, iwen_first, iwen_last, ien_last, done_cyc;

  ntt_stage_sequencer #(.IDX_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .conf      (conf),
    .hold      (hold),
    .sel       (sel),
    .i         (i),
    .j         (j),
    .k         (k),
    .p         (p),
    .iren      (iren),
    .iwen      (iwen),
    .ien       (ien),
    .done_flag (done_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue a start in the current cycle, then log ncyc cycles. Optional hold
  // window [hs, hs+hl) and two stray start pulses carrying altered mode/conf.
  task automatic run(input logic [2:0] cf, input logic md, input int hs, input int hl,
                     input int s1, input int s2, input int ncyc);
    start = 1'b1; conf = cf; mode = md; hold = 1'b0;
    iren_cnt = 0; iwen_cnt = 0; ien_cnt = 0;
    iren_first = 0; iren_last = 0; iwen_first = 0; iwen_last = 0;
    ien_last = 0; done_cyc = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == s1) || (c == s2);
      mode  = start ? ~md : md;
      conf  = start ? 3'd7 : cf;
      hold  = (c >= hs) && (c < hs + hl);
      #1;
      iren_l[c] = iren; iwen_l[c] = iwen; i_l[c] = i; j_l[c] = j; k_l[c] = k;
      p_l[c] = p; flag_l[c] = done_flag; sel_l[c] = sel;
      if (iren) begin if (iren_cnt == 0) iren_first = c; iren_cnt++; iren_last = c; end
      if (iwen) begin if (iwen_cnt == 0) iwen_first = c; iwen_cnt++; iwen_last = c; end
      if (ien)  begin ien_cnt++; ien_last = c; end
      if (done_flag == 2'b10 && done_cyc == 0) done_cyc = c;
    end
    start = 1'b0; hold = 1'b0; mode = md; conf = cf;
  endtask

  initial begin
    int quiet;
    n_err = 0; n_checks = 0;
    rst = 1'b0; start = 1'b0; mode = 1'b0; conf = 3'd0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iren", iren, 0);
    check("rst_iwen", iwen, 0);
    check("rst_ien", ien, 0);
    check("rst_flag", done_flag, 0);
    check("rst_ip", {i, p}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single NTT stage.
    run(3'd0, 1'b0, 0, 0, -1, -1, 45);
    check("t1_iren_first", iren_first, 1);
    check("t1_iren_last", iren_last, 32);
    check("t1_iren_cnt", iren_cnt, 32);
    check("t1_iwen_first", iwen_first, 8);
    check("t1_iwen_last", iwen_last, 39);
    check("t1_iwen_cnt", iwen_cnt, 32);
    check("t1_ien_last", ien_last, 39);
    check("t1_flag_busy", flag_l[1], 1);
    check("t1_flag_done_cyc", flag_l[40], 1);
    check("t1_done_cyc", done_cyc, 41);
    check("t1_k_p0", k_l[11], 10);
    check("t1_j_p0", j_l[11], 0);

    // Three INTT stages.
    run(3'd2, 1'b1, 0, 0, -1, -1, 140);
    check("t2_sel", sel_l[5], 1);
    check("t2_p0", p_l[1], 0);
    check("t2_p1", p_l[46], 1);
    check("t2_p2", p_l[91], 2);
    check("t2_gap_first", iren_l[33], 0);
    check("t2_gap_last", iren_l[45], 0);
    check("t2_stage1_iren", iren_l[46], 1);
    check("t2_iren_cnt", iren_cnt, 96);
    check("t2_iwen_cnt", iwen_cnt, 96);
    check("t2_iwen_last", iwen_last, 135);
    check("t2_ien_last", ien_last, 135);
    check("t2_done_cyc", done_cyc, 137);
    check("t2_j_p2", j_l[104], 1);
    check("t2_k_p2", k_l[104], 3);

    // Hold for 3 cycles at i=10.
    run(3'd1, 1'b0, 11, 3, -1, -1, 90);
    check("t3_i_frozen", i_l[13], 10);
    check("t3_iren_held", iren_l[12], 0);
    check("t3_iwen_pre", iwen_l[17], 1);
    check("t3_iwen_gap0", iwen_l[18], 0);
    check("t3_iwen_gap2", iwen_l[20], 0);
    check("t3_iwen_post", iwen_l[21], 1);
    check("t3_iren_cnt", iren_cnt, 64);
    check("t3_iwen_cnt", iwen_cnt, 64);
    check("t3_done_cyc", done_cyc, 83);

    // Stray starts during DRAIN (cycle 35) and DONE (cycle 40).
    run(3'd0, 1'b0, 0, 0, 35, 40, 50);
    check("t6_flag_drain", flag_l[36], 1);
    check("t6_ip_drain", {i_l[36], p_l[36]}, 0);
    check("t6_sel", sel_l[38], 0);
    check("t6_iwen_last", iwen_last, 39);
    check("t6_iren_cnt", iren_cnt, 32);
    check("t6_done_cyc", done_cyc, 41);
    check("t6_flag_after", flag_l[50], 2);

    // All seven stages, exercising the saturated butterfly span.
    run(3'd6, 1'b0, 0, 0, -1, -1, 280);
    check("t7_j_p3", j_l[131], 5);
    check("t7_k_p3", k_l[131], 1);
    check("t7_p6", p_l[235], 6);
    check("t7_j_p6", j_l[242], 7);
    check("t7_k_p6", k_l[242], 0);
    check("t7_iwen_cnt", iwen_cnt, 224);
    check("t7_done_cyc", done_cyc, 275);

    // Illegal conf, then recovery.
    run(3'd7, 1'b0, 0, 0, -1, -1, 6);
    check("t4_flag_err", flag_l[1], 3);
    check("t4_flag_err_hold", flag_l[6], 3);
    check("t4_iren_cnt", iren_cnt, 0);
    check("t4_ien_cnt", ien_cnt, 0);
    run(3'd0, 1'b0, 0, 0, -1, -1, 45);
    check("t4_flag_busy", flag_l[1], 1);
    check("t4_iwen_cnt", iwen_cnt, 32);
    check("t4_done_cyc", done_cyc, 41);

    // Asynchronous reset mid-ISSUE at p=1, i=20.
    run(3'd1, 1'b0, 0, 0, -1, -1, 60);
    check("t5_pre_i", i_l[60], 20);
    check("t5_pre_p", p_l[60], 1);
    rst = 1'b0;
    #1;
    check("t5_i", i, 0);
    check("t5_p", p, 0);
    check("t5_iren", iren, 0);
    check("t5_iwen", iwen, 0);
    check("t5_ien", ien, 0);
    check("t5_flag", done_flag, 0);
    check("t5_sel_jk", {sel, j, k}, 0);
    #2;
    rst = 1'b1;
    quiet = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (iwen) quiet++;
    end
    check("t5_iwen_after", quiet, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
